// File: rtl/mem_responder_pkg.sv
// Shared definitions for the RV32 core's memory port: access size encoding,
// MMIO register offsets and the size/alignment helpers.
package mem_responder_pkg;

    // Access size and signedness carried on mem_size.
    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_addr_t;

    // Byte offsets of the MMIO registers inside the 16-byte window.
    localparam logic [3:0] MMIO_HALT    = 4'h0;
    localparam logic [3:0] MMIO_CONSOLE = 4'h4;
    localparam logic [3:0] MMIO_STATUS  = 4'h8;
    localparam logic [3:0] MMIO_CYCLE   = 4'hC;

    // True for the five encodings the core is allowed to issue.
    function automatic logic sizeLegal(input logic [2:0] size);
        logic ok;
        case (size)
            MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU: ok = 1'b1;
            default:                             ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Halfwords need an even address, words need a 4-byte aligned address.
    function automatic logic isAligned(input logic [1:0] lo, input logic [2:0] size);
        logic ok;
        case (size)
            MEM_H, MEM_HU: ok = (lo[0] == 1'b0);
            MEM_W:         ok = (lo == 2'b00);
            default:       ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Memory port between the microcoded core (master) and the responder (slave).
interface mem_responder_if;

    logic        mem_read;
    logic        mem_wren;
    logic [31:0] mem_addr;
    logic [2:0]  mem_size;
    logic [31:0] memwrite_data;
    logic [31:0] memread_data;

    modport master (
        output mem_read,
        output mem_wren,
        output mem_addr,
        output mem_size,
        output memwrite_data,
        input  memread_data
    );

    modport slave (
        input  mem_read,
        input  mem_wren,
        input  mem_addr,
        input  mem_size,
        input  memwrite_data,
        output memread_data
    );

endinterface

// File: rtl/mem_responder_con_fifo.sv
// Console output FIFO: byte-wide, valid/ready pop at the head, push with a
// drop indication when full, and a free-entry count for the STATUS register.
module con_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [7:0]                 i_pushData,
    output logic                       o_drop,
    output logic [$clog2(DEPTH):0]     o_free,
    output logic [7:0]                 o_data,
    output logic                       o_valid,
    input  logic                       i_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    r_data [DEPTH];
    logic [AW-1:0] r_rdPtr;
    logic [AW-1:0] r_wrPtr;
    logic [CW-1:0] r_count;

    logic w_full;
    logic w_pop;
    logic w_accept;

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_full   = (r_count == CW'(DEPTH));
    assign w_pop    = o_valid & i_ready;
    assign w_accept = i_push & (~w_full | w_pop);
    assign o_drop   = i_push & w_full & ~w_pop;
    assign o_valid  = (r_count != '0);
    assign o_data   = r_data[r_rdPtr];
    assign o_free   = CW'(DEPTH) - r_count;

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_data[r_wrPtr] <= i_pushData;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_accept) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: unified instruction/data RAM with byte-lane access,
// plus an MMIO window holding HALT, CONSOLE, STATUS and a free-running CYCLE
// counter. Reads are combinational so the core can sample them in the same
// cycle it issues the request; writes commit on the clock edge.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS = 4096,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] MMIO_BASE   = 32'h0800_0000,
    parameter int          CON_DEPTH   = 4,
    parameter              INIT_FILE   = ""
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_responder_if.slave       bus,
    output logic [7:0]           con_data,
    output logic                 con_valid,
    input  logic                 con_ready,
    output logic                 halted,
    output logic [31:0]          halt_code,
    output logic                 bus_err
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam int          FW        = $clog2(CON_DEPTH) + 1;
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic        r_halted;
    logic [31:0] r_haltCode;
    logic        r_busErr;
    logic [31:0] r_cycle;

    logic          w_access;
    logic          w_inRam;
    logic          w_inMmio;
    logic          w_addrOk;
    logic          w_accessOk;
    logic          w_accessErr;
    logic [1:0]    w_lo;
    logic [3:0]    w_offset;
    logic [AW-1:0] w_wordIdx;
    logic [31:0]   w_ramWord;
    logic [7:0]    w_byteSel;
    logic [15:0]   w_halfSel;
    logic [31:0]   w_laneData;
    logic [31:0]   w_mmioData;
    logic [31:0]   w_readData;
    logic [3:0]    w_byteEn;
    logic [31:0]   w_storeData;
    logic          w_ramWe;
    logic          w_mmioWe;
    logic          w_haltWe;
    logic          w_conPush;
    logic          w_conDrop;
    logic [FW-1:0] w_conFree;

    // Address decode: RAM at the bottom, 16-byte MMIO window at MMIO_BASE
    // that only accepts word accesses.
    assign w_access    = bus.mem_read | bus.mem_wren;
    assign w_lo        = bus.mem_addr[1:0];
    assign w_offset    = bus.mem_addr[3:0];
    assign w_wordIdx   = bus.mem_addr[AW+1:2];
    assign w_inRam     = (bus.mem_addr < RAM_BYTES);
    assign w_inMmio    = (bus.mem_addr[31:4] == MMIO_BASE[31:4]);
    assign w_addrOk    = w_inRam | (w_inMmio & (bus.mem_size == MEM_W));
    assign w_accessOk  = sizeLegal(bus.mem_size) & isAligned(w_lo, bus.mem_size) & w_addrOk;
    assign w_accessErr = w_access & ~w_accessOk;
    assign w_ramWord   = r_mem[w_wordIdx];

    assign w_ramWe   = bus.mem_wren & w_accessOk & w_inRam;
    assign w_mmioWe  = bus.mem_wren & w_accessOk & ~w_inRam & w_inMmio;
    assign w_haltWe  = w_mmioWe & (w_offset == MMIO_HALT) & ~r_halted;
    assign w_conPush = w_mmioWe & (w_offset == MMIO_CONSOLE);

    // Pick the addressed byte/halfword out of the RAM word and extend it.
    always_comb begin
        case (w_lo)
            2'd0:    w_byteSel = w_ramWord[7:0];
            2'd1:    w_byteSel = w_ramWord[15:8];
            2'd2:    w_byteSel = w_ramWord[23:16];
            default: w_byteSel = w_ramWord[31:24];
        endcase
        w_halfSel = w_lo[1] ? w_ramWord[31:16] : w_ramWord[15:0];
        case (bus.mem_size)
            MEM_B:   w_laneData = {{24{w_byteSel[7]}}, w_byteSel};
            MEM_BU:  w_laneData = {24'b0, w_byteSel};
            MEM_H:   w_laneData = {{16{w_halfSel[15]}}, w_halfSel};
            MEM_HU:  w_laneData = {16'b0, w_halfSel};
            MEM_W:   w_laneData = w_ramWord;
            default: w_laneData = '0;
        endcase
    end

    // MMIO read values; the write-only CONSOLE register reads as zero.
    always_comb begin
        case (w_offset)
            MMIO_HALT:   w_mmioData = {31'b0, r_halted};
            MMIO_STATUS: w_mmioData = {r_busErr, 27'b0, 4'(w_conFree)};
            MMIO_CYCLE:  w_mmioData = r_cycle;
            default:     w_mmioData = '0;
        endcase
    end

    // Read-data mux: boot vector during reset, zero when idle or on error.
    always_comb begin
        w_readData = '0;
        if (!rst_n) begin
            w_readData = RESET_PC;
        end else if (bus.mem_read && w_accessOk) begin
            if (w_inRam) begin
                w_readData = w_laneData;
            end else begin
                w_readData = w_mmioData;
            end
        end
    end

    assign bus.memread_data = w_readData;

    // Replicate store data across lanes and enable only the addressed bytes.
    always_comb begin
        w_byteEn    = '0;
        w_storeData = bus.memwrite_data;
        case (bus.mem_size)
            MEM_B, MEM_BU: begin
                w_byteEn    = 4'b0001 << w_lo;
                w_storeData = {4{bus.memwrite_data[7:0]}};
            end
            MEM_H, MEM_HU: begin
                w_byteEn    = w_lo[1] ? 4'b1100 : 4'b0011;
                w_storeData = {2{bus.memwrite_data[15:0]}};
            end
            MEM_W: begin
                w_byteEn = 4'b1111;
            end
            default: begin
                w_byteEn = 4'b0000;
            end
        endcase
    end

    // RAM byte-lane writes; a same-cycle read still sees the old word.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (w_ramWe && w_byteEn[b]) begin
                r_mem[w_wordIdx][8*b +: 8] <= w_storeData[8*b +: 8];
            end
        end
    end

    // Halt capture (first write wins), sticky error flag and cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_halted   <= 1'b0;
            r_haltCode <= '0;
            r_busErr   <= 1'b0;
            r_cycle    <= '0;
        end else begin
            if (w_haltWe) begin
                r_halted   <= 1'b1;
                r_haltCode <= bus.memwrite_data;
            end
            r_busErr <= r_busErr | w_accessErr | w_conDrop;
            r_cycle  <= r_cycle + 32'd1;
        end
    end

    con_fifo #(
        .DEPTH (CON_DEPTH)
    ) u_conFifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (w_conPush),
        .i_pushData (bus.memwrite_data[7:0]),
        .o_drop     (w_conDrop),
        .o_free     (w_conFree),
        .o_data     (con_data),
        .o_valid    (con_valid),
        .i_ready    (con_ready)
    );

    assign halted    = r_halted;
    assign halt_code = r_haltCode;
    assign bus_err   = r_busErr;

endmodule
